// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: pre-adder, 18x18 multiplier, 48-bit post-adder with optional pipeline registers.
// Define DSP_PARAM_CHECK_EN to get simulation-time checks of the configuration parameters.

// Pipeline register with synchronous reset, clock enable and optional bypass
module dsp48a1_reg #(
   parameter int unsigned W  = 1,
   parameter int          EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] r;

   always_ff @(posedge clk) begin
      if (rst)     r <= '0;
      else if (ce) r <= d;
   end

   assign q = (EN == 1) ? r : d;
endmodule

module dsp48a1_slice #(
   parameter int    A0REG       = 0,
   parameter int    A1REG       = 1,
   parameter int    B0REG       = 0,
   parameter int    B1REG       = 1,
   parameter int    CREG        = 1,
   parameter int    DREG        = 1,
   parameter int    MREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    OPMODEREG   = 1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT",
   parameter string RSTTYPE     = "SYNC"
) (
   input  logic        CLK,
   input  logic        RSTA,
   input  logic        RSTB,
   input  logic        RSTC,
   input  logic        RSTD,
   input  logic        RSTM,
   input  logic        RSTP,
   input  logic        RSTCARRYIN,
   input  logic        RSTOPMODE,
   input  logic        CEA,
   input  logic        CEB,
   input  logic        CEC,
   input  logic        CED,
   input  logic        CEM,
   input  logic        CEP,
   input  logic        CECARRYIN,
   input  logic        CEOPMODE,
   input  logic [17:0] A,
   input  logic [17:0] B,
   input  logic [17:0] D,
   input  logic [17:0] BCIN,
   input  logic [47:0] C,
   input  logic [47:0] PCIN,
   input  logic        CARRYIN,
   input  logic [7:0]  OPMODE,
   output logic [35:0] M,
   output logic [47:0] P,
   output logic [47:0] PCOUT,
   output logic [17:0] BCOUT,
   output logic        CARRYOUT,
   output logic        CARRYOUTF
);
   localparam int unsigned DW = 18;
   localparam int unsigned MW = 36;
   localparam int unsigned PW = 48;

   localparam bit CIN_FROM_OP   = (CARRYINSEL == "OPMODE5");
   localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");
   localparam bit B_FROM_PORT   = (B_INPUT == "DIRECT");
   localparam bit B_FROM_CASC   = (B_INPUT == "CASCADE");

`ifdef DSP_PARAM_CHECK_EN
   function automatic bit reg_param_bad(input int v);
      return (v != 0) && (v != 1);
   endfunction

   initial begin
      if (!CIN_FROM_OP && !CIN_FROM_PORT) $error("dsp48a1_slice: illegal CARRYINSEL %s", CARRYINSEL);
      if (!B_FROM_PORT && !B_FROM_CASC)   $error("dsp48a1_slice: illegal B_INPUT %s", B_INPUT);
      if (RSTTYPE != "SYNC")              $error("dsp48a1_slice: illegal RSTTYPE %s", RSTTYPE);
      if (reg_param_bad(A0REG) || reg_param_bad(A1REG) || reg_param_bad(B0REG) ||
          reg_param_bad(B1REG) || reg_param_bad(CREG)  || reg_param_bad(DREG)  ||
          reg_param_bad(MREG)  || reg_param_bad(PREG)  || reg_param_bad(CARRYINREG) ||
          reg_param_bad(CARRYOUTREG) || reg_param_bad(OPMODEREG))
         $error("dsp48a1_slice: register enable parameter outside {0,1}");
   end
`endif

   logic [7:0]    op;
   logic [DW-1:0] b0_d, b0, a0, a1, b1_d, b1, d_q, pre;
   logic [PW-1:0] c_q;
   logic [MW-1:0] m_d;
   logic          cin_d, cin;
   logic [PW-1:0] x_mux, z_mux, p_q;
   logic [PW:0]   res;
   logic          co_q;

   dsp48a1_reg #(.W(8),  .EN(OPMODEREG)) u_op (.clk(CLK), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op));
   dsp48a1_reg #(.W(DW), .EN(DREG))      u_d  (.clk(CLK), .rst(RSTD), .ce(CED), .d(D), .q(d_q));
   dsp48a1_reg #(.W(PW), .EN(CREG))      u_c  (.clk(CLK), .rst(RSTC), .ce(CEC), .d(C), .q(c_q));
   dsp48a1_reg #(.W(DW), .EN(A0REG))     u_a0 (.clk(CLK), .rst(RSTA), .ce(CEA), .d(A), .q(a0));
   dsp48a1_reg #(.W(DW), .EN(A1REG))     u_a1 (.clk(CLK), .rst(RSTA), .ce(CEA), .d(a0), .q(a1));

   // An illegal B_INPUT feeds zeros into the B path
   assign b0_d = B_FROM_PORT ? B : (B_FROM_CASC ? BCIN : '0);
   dsp48a1_reg #(.W(DW), .EN(B0REG)) u_b0 (.clk(CLK), .rst(RSTB), .ce(CEB), .d(b0_d), .q(b0));

   assign pre  = op[6] ? (d_q - b0) : (d_q + b0);
   assign b1_d = op[4] ? pre : b0;
   dsp48a1_reg #(.W(DW), .EN(B1REG)) u_b1 (.clk(CLK), .rst(RSTB), .ce(CEB), .d(b1_d), .q(b1));

   assign m_d = MW'(a1) * MW'(b1);
   dsp48a1_reg #(.W(MW), .EN(MREG)) u_m (.clk(CLK), .rst(RSTM), .ce(CEM), .d(m_d), .q(M));

   // An illegal CARRYINSEL forces carry-in to zero
   assign cin_d = CIN_FROM_OP ? op[5] : (CIN_FROM_PORT ? CARRYIN : 1'b0);
   dsp48a1_reg #(.W(1), .EN(CARRYINREG)) u_cin (.clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_d), .q(cin));

   // Operand muxes and 49-bit post-adder; feedback always taken from the P register
   always_comb begin
      x_mux = '0;
      z_mux = '0;
      case (op[1:0])
         2'd1:    x_mux = PW'(M);
         2'd2:    x_mux = p_q;
         2'd3:    x_mux = {d_q[11:0], a1, b1};
         default: x_mux = '0;
      endcase
      case (op[3:2])
         2'd1:    z_mux = PCIN;
         2'd2:    z_mux = p_q;
         2'd3:    z_mux = c_q;
         default: z_mux = '0;
      endcase
      if (op[7]) res = {1'b0, z_mux} - ({1'b0, x_mux} + (PW+1)'(cin));
      else       res = {1'b0, z_mux} + {1'b0, x_mux} + (PW+1)'(cin);
   end

   always_ff @(posedge CLK) begin
      if (RSTP) begin
         p_q  <= '0;
         co_q <= 1'b0;
      end else if (CEP) begin
         p_q  <= res[PW-1:0];
         co_q <= res[PW];
      end
   end

   assign P         = (PREG == 1) ? p_q : res[PW-1:0];
   assign PCOUT     = P;
   assign BCOUT     = b1;
   assign CARRYOUT  = (CARRYOUTREG == 1) ? co_q : res[PW];
   assign CARRYOUTF = CARRYOUT;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed self-checking bench for dsp48a1_slice in its default configuration.
module tb_dsp48a1_slice;
   logic        clk;
   logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcin, rstop;
   logic        cea, ceb, cec, ced, cem, cep, cecin, ceop;
   logic [17:0] a, b, d, bcin;
   logic [47:0] c, pcin;
   logic        carryin;
   logic [7:0]  opmode;
   logic [35:0] m;
   logic [47:0] p, pcout;
   logic [17:0] bcout;
   logic        carryout, carryoutf;

   int checks = 0;
   int errors = 0;

   dsp48a1_slice dut (
      .CLK(clk),
      .RSTA(rsta), .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm), .RSTP(rstp),
      .RSTCARRYIN(rstcin), .RSTOPMODE(rstop),
      .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem), .CEP(cep),
      .CECARRYIN(cecin), .CEOPMODE(ceop),
      .A(a), .B(b), .D(d), .BCIN(bcin), .C(c), .PCIN(pcin),
      .CARRYIN(carryin), .OPMODE(opmode),
      .M(m), .P(p), .PCOUT(pcout), .BCOUT(bcout),
      .CARRYOUT(carryout), .CARRYOUTF(carryoutf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_rst(input logic v);
      rsta = v; rstb = v; rstc = v; rstd = v; rstm = v; rstp = v; rstcin = v; rstop = v;
   endtask

   task automatic set_ce(input logic v);
      cea = v; ceb = v; cec = v; ced = v; cem = v; cep = v; cecin = v; ceop = v;
   endtask

   task automatic check_all(input string tag, input logic [17:0] e_bc, input logic [35:0] e_m,
                            input logic [47:0] e_p, input logic e_co);
      check({tag, ".bcout"},     48'(bcout),     48'(e_bc));
      check({tag, ".m"},         48'(m),         48'(e_m));
      check({tag, ".p"},         p,              e_p);
      check({tag, ".pcout"},     pcout,          e_p);
      check({tag, ".carryout"},  48'(carryout),  48'(e_co));
      check({tag, ".carryoutf"}, 48'(carryoutf), 48'(e_co));
   endtask

   initial begin
      set_rst(1'b1);
      set_ce(1'b1);
      a = '0; b = '0; d = '0; bcin = '0; c = '0; pcin = '0; carryin = 1'b0; opmode = '0;
      @(negedge clk);

      // reset dominates random data, enables and opmode
      for (int i = 0; i < 4; i++) begin
         a = 18'($urandom); b = 18'($urandom); d = 18'($urandom); bcin = 18'($urandom);
         c = 48'({$urandom, $urandom}); pcin = 48'({$urandom, $urandom});
         carryin = 1'($urandom); opmode = 8'($urandom);
         cea = 1'($urandom); ceb = 1'($urandom); cec = 1'($urandom); ced = 1'($urandom);
         cem = 1'($urandom); cep = 1'($urandom); cecin = 1'($urandom); ceop = 1'($urandom);
         clocks(1);
         check_all("reset", 18'd0, 36'd0, 48'd0, 1'b0);
      end

      set_rst(1'b0);
      set_ce(1'b1);
      carryin = 1'b0; bcin = '0; pcin = '0;
      opmode = 8'hDD; a = 18'd20; b = 18'd10; c = 48'd350; d = 18'd25;
      clocks(4);
      check_all("op_dd", 18'd15, 36'd300, 48'd50, 1'b0);

      opmode = 8'h10;
      clocks(3);
      check_all("op_10", 18'd35, 36'd700, 48'd0, 1'b0);

      opmode = 8'h0A;
      clocks(3);
      check_all("op_0a", 18'd10, 36'd200, 48'd0, 1'b0);

      opmode = 8'hA7; a = 18'd5; b = 18'd6; d = 18'd25; pcin = 48'd3000;
      clocks(3);
      check_all("op_a7", 18'd6, 36'd30, 48'hFE6F_FFEC_0BB1, 1'b1);

      // P and carry hold while CEP is low even though the operation changes
      cep = 1'b0; opmode = 8'h0C;
      clocks(3);
      check("hold.p", p, 48'hFE6F_FFEC_0BB1);
      check("hold.carryout", 48'(carryout), 48'd1);

      rstp = 1'b1;
      clocks(1);
      check("rstp.p", p, 48'd0);
      check("rstp.pcout", pcout, 48'd0);
      check("rstp.carryout", 48'(carryout), 48'd0);
      check("rstp.carryoutf", 48'(carryoutf), 48'd0);

      rstp = 1'b0; cep = 1'b1;
      clocks(2);
      check("op_0c.p", p, 48'd350);

      // accumulate M (30) onto P each cycle
      opmode = 8'h09;
      clocks(3);
      check("acc.p", p, 48'd410);
      check("acc.carryout", 48'(carryout), 48'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
